// File: rtl/tartaruga_pkg.sv
// -----------------------------------------------------------------------------
// tartaruga_pkg
// Shared types for the memory-side blocks of the cache subsystem.
//   bus32_t          : 32-bit bus address
//   line_t           : one 128-bit cache line
//   mem_arb_state_t  : states of the line-memory arbiter
// -----------------------------------------------------------------------------
package tartaruga_pkg;

   localparam int LINE_W = 128;

   typedef logic [31:0]       bus32_t;
   typedef logic [LINE_W-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2,
      RESP     = 2'd3
   } mem_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at index `ptr`
// and wraps modulo NUM_REQ; the first asserted request wins.
// Ports:
//   req     in  NUM_REQ : request vector
//   ptr     in  IDX_W   : highest-priority index for this pick (< NUM_REQ)
//   gnt     out NUM_REQ : one-hot grant (all zero when no request)
//   gnt_idx out IDX_W   : binary index of the winner (0 when no request)
//   any     out 1       : at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int  NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      cand    = '0;
      // Walk the requesters in priority order ptr, ptr+1, ... (wrapping);
      // the first hit is kept and later hits are ignored.
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!any && req[cand]) begin
            any     = 1'b1;
            gnt_idx = cand;
         end
      end
      if (any) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one blocking line-memory port (one outstanding transaction) between
// NUM_REQ cache requesters with round-robin fairness. A granted request is
// latched, issued to memory, its response captured and returned to the
// requester that issued it before the next grant.
// Ports:
//   clk_i, rstn_i            : clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o  : per-requester request handshake
//   req_addr_i/req_we_i/req_data_i : per-requester line address, write flag, write line
//   rsp_valid_o/rsp_ready_i  : per-requester response handshake (owner only)
//   rsp_addr_o/rsp_data_o    : shared response address / read line
//   mem_req_*                : request side of the memory wrapper
//   mem_rsp_*                : response side of the memory wrapper
//   err_o                    : sticky protocol error (unexpected or mismatched response)
// -----------------------------------------------------------------------------
module mem_arbiter
   import tartaruga_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,

   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ-1:0][31:0]  req_addr_i,
   input  logic [NUM_REQ-1:0]        req_we_i,
   input  logic [NUM_REQ-1:0][127:0] req_data_i,

   output logic [NUM_REQ-1:0]        rsp_valid_o,
   input  logic [NUM_REQ-1:0]        rsp_ready_i,
   output logic [31:0]               rsp_addr_o,
   output logic [127:0]              rsp_data_o,

   output logic                      mem_req_valid_o,
   input  logic                      mem_req_ready_i,
   output logic [31:0]               mem_addr_o,
   output logic                      mem_we_o,
   output logic [127:0]              mem_data_wr_o,

   input  logic                      mem_rsp_valid_i,
   output logic                      mem_rsp_ready_o,
   input  logic [31:0]               mem_rsp_addr_i,
   input  logic [127:0]              mem_data_line_i,

   output logic                      err_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   mem_arb_state_t   state_reg, state_next;
   logic [IDX_W-1:0] rr_ptr_reg;
   logic [IDX_W-1:0] owner_reg;
   bus32_t           addr_reg;
   logic             we_reg;
   line_t            data_reg;
   bus32_t           rsp_addr_reg;
   line_t            rsp_data_reg;
   logic             err_reg;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic               grant_fire;
   logic               rsp_capture;
   logic               err_set;
   logic [IDX_W-1:0]   rr_ptr_next;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req     (req_valid_i),
      .ptr     (rr_ptr_reg),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   // Pointer moves just past the winner so that winner gets lowest priority next.
   assign rr_ptr_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

   // Next-state and handshake outputs
   always_comb begin
      state_next      = state_reg;
      req_ready_o     = '0;
      rsp_valid_o     = '0;
      mem_req_valid_o = 1'b0;
      mem_rsp_ready_o = 1'b0;
      grant_fire      = 1'b0;
      rsp_capture     = 1'b0;
      case (state_reg)
         IDLE: begin
            // The grant is the handshake: ready only goes to a valid requester.
            if (arb_any) begin
               req_ready_o = arb_gnt;
               grant_fire  = 1'b1;
               state_next  = ISSUE;
            end
         end
         ISSUE: begin
            mem_req_valid_o = 1'b1;
            if (mem_req_ready_i) begin
               state_next = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            mem_rsp_ready_o = 1'b1;
            if (mem_rsp_valid_i) begin
               rsp_capture = 1'b1;
               state_next  = RESP;
            end
         end
         RESP: begin
            rsp_valid_o[owner_reg] = 1'b1;
            if (rsp_ready_i[owner_reg]) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A response outside WAIT_RSP is dropped; a response for another address
   // is still delivered but flagged.
   assign err_set = (mem_rsp_valid_i && (state_reg != WAIT_RSP)) ||
                    (rsp_capture && (mem_rsp_addr_i != addr_reg));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= '0;
         owner_reg    <= '0;
         addr_reg     <= '0;
         we_reg       <= 1'b0;
         data_reg     <= '0;
         rsp_addr_reg <= '0;
         rsp_data_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (grant_fire) begin
            owner_reg  <= arb_idx;
            addr_reg   <= req_addr_i[arb_idx];
            we_reg     <= req_we_i[arb_idx];
            data_reg   <= req_data_i[arb_idx];
            rr_ptr_reg <= rr_ptr_next;
         end
         if (rsp_capture) begin
            rsp_addr_reg <= mem_rsp_addr_i;
            rsp_data_reg <= mem_data_line_i;
         end
         if (err_set) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign mem_addr_o    = addr_reg;
   assign mem_we_o      = we_reg;
   assign mem_data_wr_o = data_reg;
   assign rsp_addr_o    = rsp_addr_reg;
   assign rsp_data_o    = rsp_data_reg;
   assign err_o         = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by a randomized run. A requester driver and a
// memory model feed the DUT; a monitor predicts grants with a round-robin
// rule, pushes expected transactions into a scoreboard queue and compares
// every DUT output against it each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   import tartaruga_pkg::*;

   localparam int N = 2;

   logic                clk_i = 1'b0;
   logic                rstn_i = 1'b0;
   logic [N-1:0]        req_valid_i;
   logic [N-1:0]        req_ready_o;
   logic [N-1:0][31:0]  req_addr_i;
   logic [N-1:0]        req_we_i;
   logic [N-1:0][127:0] req_data_i;
   logic [N-1:0]        rsp_valid_o;
   logic [N-1:0]        rsp_ready_i;
   logic [31:0]         rsp_addr_o;
   logic [127:0]        rsp_data_o;
   logic                mem_req_valid_o;
   logic                mem_req_ready_i;
   logic [31:0]         mem_addr_o;
   logic                mem_we_o;
   logic [127:0]        mem_data_wr_o;
   logic                mem_rsp_valid_i;
   logic                mem_rsp_ready_o;
   logic [31:0]         mem_rsp_addr_i;
   logic [127:0]        mem_data_line_i;
   logic                err_o;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(.NUM_REQ(N)) dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_addr_i      (req_addr_i),
      .req_we_i        (req_we_i),
      .req_data_i      (req_data_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i),
      .rsp_addr_o      (rsp_addr_o),
      .rsp_data_o      (rsp_data_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_addr_o      (mem_addr_o),
      .mem_we_o        (mem_we_o),
      .mem_data_wr_o   (mem_data_wr_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_ready_o (mem_rsp_ready_o),
      .mem_rsp_addr_i  (mem_rsp_addr_i),
      .mem_data_line_i (mem_data_line_i),
      .err_o           (err_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      line_t       data;
   } req_t;

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic        we;
      line_t       data;
   } txn_t;

   int checks = 0;
   int errors = 0;

   // stimulus controls
   req_t pq[N][$];
   int   stall[N];
   bit   rsp_rand = 1'b0;
   bit   rdy_rand = 1'b0;
   bit   lat_random = 1'b0;
   int   lat = 10;
   int   hold_rdy = 0;
   bit   corrupt_req = 1'b0;
   bit   spur_req = 1'b0;
   logic [N-1:0] wait_rsp;

   // memory contents: one copy for the reference, one inside the memory model
   line_t ref_store[bit [31:0]];
   line_t mem_store[bit [31:0]];

   // reference model state
   txn_t        sbq[$];
   int          grant_log[$];
   int          done_count = 0;
   int          m_ptr = 0;
   bit          m_busy = 1'b0, m_issue = 1'b0, m_wait = 1'b0, m_resp = 1'b0;
   bit          err_exp = 1'b0;
   logic [31:0] m_rsp_addr;
   int          last_rsp_port = -1;
   logic [31:0] last_rsp_addr;
   line_t       last_rsp_data;

   function automatic line_t init_line(input logic [31:0] a);
      return {a ^ 32'hA5A5_A5A5, ~a, a + 32'h1357_9BDF, 32'h5A5A_0000 | {16'h0, a[15:0]}};
   endfunction

   function automatic line_t read_ref(input logic [31:0] a);
      if (ref_store.exists(a)) return ref_store[a];
      return init_line(a);
   endfunction

   function automatic line_t read_mem(input logic [31:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return init_line(a);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- requester driver ----------------
   initial begin
      logic [N-1:0] hs, rh, seenv;
      bit           rst_seen;
      req_t         r;
      req_valid_i = '0;
      rsp_ready_i = '0;
      req_addr_i  = '0;
      req_we_i    = '0;
      req_data_i  = '0;
      wait_rsp    = '0;
      for (int p = 0; p < N; p++) stall[p] = 0;
      forever begin
         @(negedge clk_i);
         rst_seen = !rstn_i;
         hs    = req_valid_i & req_ready_o;
         rh    = rsp_valid_o & rsp_ready_i;
         seenv = rsp_valid_o;
         @(posedge clk_i);
         #1;
         if (rst_seen) begin
            req_valid_i = '0;
            rsp_ready_i = '0;
            wait_rsp    = '0;
            continue;
         end
         for (int p = 0; p < N; p++) begin
            if (hs[p]) begin
               req_valid_i[p] = 1'b0;
               wait_rsp[p]    = 1'b1;
            end
            if (rh[p]) wait_rsp[p] = 1'b0;
            if (!req_valid_i[p] && !wait_rsp[p] && pq[p].size() > 0) begin
               r = pq[p].pop_front();
               req_valid_i[p] = 1'b1;
               req_addr_i[p]  = r.addr;
               req_we_i[p]    = r.we;
               req_data_i[p]  = r.data;
            end
            if (stall[p] > 0) begin
               rsp_ready_i[p] = 1'b0;
               if (seenv[p]) stall[p]--;
            end else begin
               rsp_ready_i[p] = rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
         end
      end
   end

   // ---------------- memory model ----------------
   initial begin
      bit          rst_seen, acc, taken, vis, mb, spur_active;
      logic [31:0] a, m_a;
      logic        w, m_w;
      line_t       d;
      int          cnt;
      mb = 1'b0; spur_active = 1'b0; cnt = 0; m_a = '0; m_w = 1'b0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      mem_rsp_addr_i  = '0;
      mem_data_line_i = '0;
      forever begin
         @(negedge clk_i);
         rst_seen = !rstn_i;
         acc   = mem_req_valid_o && mem_req_ready_i;
         taken = mem_rsp_valid_i && mem_rsp_ready_o;
         vis   = mem_req_valid_o;
         a = mem_addr_o; w = mem_we_o; d = mem_data_wr_o;
         @(posedge clk_i);
         #1;
         if (rst_seen) begin
            mb = 1'b0; spur_active = 1'b0;
            mem_rsp_valid_i = 1'b0;
            mem_req_ready_i = 1'b0;
            continue;
         end
         if (mem_rsp_valid_i) begin
            if (spur_active) begin
               mem_rsp_valid_i = 1'b0;
               spur_active = 1'b0;
            end else if (taken) begin
               mem_rsp_valid_i = 1'b0;
               mb = 1'b0;
            end
         end
         if (acc) begin
            mb = 1'b1; m_a = a; m_w = w;
            cnt = lat_random ? int'($urandom_range(1, 6)) : lat;
            if (w) mem_store[a] = d;
         end else if (mb && !mem_rsp_valid_i) begin
            if (cnt > 1) cnt--;
            else begin
               mem_rsp_valid_i = 1'b1;
               mem_rsp_addr_i  = corrupt_req ? m_a + 32'd4 : m_a;
               corrupt_req     = 1'b0;
               mem_data_line_i = m_w ? {$urandom, $urandom, $urandom, $urandom} : read_mem(m_a);
            end
         end
         if (spur_req && !mb && !mem_rsp_valid_i) begin
            spur_req = 1'b0;
            spur_active = 1'b1;
            mem_rsp_valid_i = 1'b1;
            mem_rsp_addr_i  = $urandom;
            mem_data_line_i = {$urandom, $urandom, $urandom, $urandom};
         end
         if (hold_rdy > 0) begin
            mem_req_ready_i = 1'b0;
            if (vis) hold_rdy--;
         end else begin
            mem_req_ready_i = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
   end

   // ---------------- monitor / reference model ----------------
   initial begin
      logic [N-1:0] exp_rdy, exp_rv;
      int           w, p;
      txn_t         t;
      forever begin
         @(negedge clk_i);
         if (!rstn_i) begin
            m_ptr = 0; m_busy = 0; m_issue = 0; m_wait = 0; m_resp = 0; err_exp = 0;
            sbq.delete();
            continue;
         end
         // round-robin prediction from the pointer, plain modulo arithmetic
         w = -1;
         for (int k = 0; k < N; k++) begin
            p = (m_ptr + k) % N;
            if (w < 0 && req_valid_i[p]) w = p;
         end
         exp_rdy = '0;
         if (!m_busy && w >= 0) exp_rdy[w] = 1'b1;
         chk("req_ready", req_ready_o, exp_rdy);
         chk("mem_req_valid", mem_req_valid_o, m_issue);
         if (m_issue && sbq.size() > 0) begin
            chk("mem_addr", mem_addr_o, sbq[0].addr);
            chk("mem_we", mem_we_o, sbq[0].we);
            if (sbq[0].we) chk("mem_data_wr", mem_data_wr_o, sbq[0].data);
         end
         exp_rv = '0;
         if (m_resp && sbq.size() > 0) exp_rv[sbq[0].port] = 1'b1;
         chk("rsp_valid", rsp_valid_o, exp_rv);
         if (m_resp && sbq.size() > 0) begin
            chk("rsp_addr", rsp_addr_o, m_rsp_addr);
            if (!sbq[0].we) chk("rsp_data", rsp_data_o, sbq[0].data);
         end
         chk("err", err_o, err_exp);
         if (mem_rsp_valid_i) chk("mem_rsp_ready", mem_rsp_ready_o, m_wait);

         // advance the model with this cycle's handshakes
         if (mem_rsp_valid_i && !m_wait) err_exp = 1'b1;
         if (exp_rdy != '0) begin
            t.port = w;
            t.addr = req_addr_i[w];
            t.we   = req_we_i[w];
            if (req_we_i[w]) begin
               t.data = req_data_i[w];
               ref_store[req_addr_i[w]] = req_data_i[w];
            end else begin
               t.data = read_ref(req_addr_i[w]);
            end
            sbq.push_back(t);
            grant_log.push_back(w);
            m_busy = 1'b1; m_issue = 1'b1;
            m_ptr = (w + 1) % N;
         end else if (m_issue && mem_req_ready_i) begin
            m_issue = 1'b0; m_wait = 1'b1;
         end else if (m_wait && mem_rsp_valid_i) begin
            m_wait = 1'b0; m_resp = 1'b1;
            m_rsp_addr = mem_rsp_addr_i;
            if (sbq.size() > 0 && mem_rsp_addr_i != sbq[0].addr) err_exp = 1'b1;
         end else if (m_resp && sbq.size() > 0 && rsp_ready_i[sbq[0].port]) begin
            $display("TXN port=%0d addr=%h we=%0d data=%h", sbq[0].port, rsp_addr_o, sbq[0].we, rsp_data_o);
            last_rsp_port = sbq[0].port;
            last_rsp_addr = rsp_addr_o;
            last_rsp_data = rsp_data_o;
            void'(sbq.pop_front());
            m_resp = 1'b0; m_busy = 1'b0;
            done_count++;
         end
      end
   end

   // ---------------- main sequence ----------------
   task automatic wait_idle(input string tag, input int bound);
      int n = 0;
      while ((pq[0].size() > 0 || pq[1].size() > 0 || req_valid_i != '0 || wait_rsp != '0 || m_busy) && n < bound) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (n >= bound) begin
         errors++;
         $display("FAIL %s timeout: still busy after %0d cycles, required idle", tag, n);
      end
      repeat (2) @(negedge clk_i);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req_ready"}, req_ready_o, 0);
      chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
      chk({tag, "_mem_req_valid"}, mem_req_valid_o, 0);
      chk({tag, "_mem_rsp_ready"}, mem_rsp_ready_o, 0);
      chk({tag, "_err"}, err_o, 0);
      chk({tag, "_mem_addr"}, mem_addr_o, 0);
      chk({tag, "_mem_data_wr"}, mem_data_wr_o, 0);
      chk({tag, "_rsp_addr"}, rsp_addr_o, 0);
      chk({tag, "_rsp_data"}, rsp_data_o, 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk_i);
      #2 rstn_i = 1'b0;
      #1 reset_checks(tag);
      @(negedge clk_i);
      #2 rstn_i = 1'b1;
   endtask

   function automatic req_t mk(input logic [31:0] a, input logic we, input line_t d);
      req_t r;
      r.addr = a; r.we = we; r.data = d;
      return r;
   endfunction

   initial begin
      line_t a5_line, wr_line;
      int    n, d0, pp;
      a5_line = {16{8'hA5}};
      wr_line = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      ref_store[32'h100] = a5_line;
      mem_store[32'h100] = a5_line;

      rstn_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #1 reset_checks("init");
      #1 rstn_i = 1'b1;
      @(negedge clk_i);

      // contention: both requesters loaded in the same cycle right after reset
      grant_log.delete();
      pq[0].push_back(mk(32'h1000, 1'b0, '0));
      pq[0].push_back(mk(32'h1010, 1'b0, '0));
      pq[1].push_back(mk(32'h2000, 1'b0, '0));
      pq[1].push_back(mk(32'h2010, 1'b0, '0));
      wait_idle("contention", 400);
      chk("grant_count", grant_log.size(), 4);
      if (grant_log.size() >= 4) begin
         chk("grant0", grant_log[0], 0);
         chk("grant1", grant_log[1], 1);
         chk("grant2", grant_log[2], 0);
         chk("grant3", grant_log[3], 1);
      end

      // single read of the preloaded line
      pq[0].push_back(mk(32'h100, 1'b0, '0));
      wait_idle("single_read", 200);
      chk("single_port", last_rsp_port, 0);
      chk("single_addr", last_rsp_addr, 32'h100);
      chk("single_data", last_rsp_data, a5_line);

      // write from port 1, then read it back on port 0
      pq[1].push_back(mk(32'h200, 1'b1, wr_line));
      wait_idle("write", 200);
      chk("write_port", last_rsp_port, 1);
      chk("write_mem_content", mem_store.exists(32'h200) ? mem_store[32'h200] : '0, wr_line);
      pq[0].push_back(mk(32'h200, 1'b0, '0));
      wait_idle("readback", 200);
      chk("readback_data", last_rsp_data, wr_line);

      // backpressure on both memory request and requester response
      hold_rdy = 5;
      stall[0] = 4;
      pq[0].push_back(mk(32'h300, 1'b0, '0));
      repeat (3) @(negedge clk_i);
      pq[1].push_back(mk(32'h310, 1'b0, '0));
      wait_idle("backpressure", 300);
      chk("bp_hold_consumed", hold_rdy, 0);
      chk("bp_stall_consumed", stall[0], 0);
      chk("bp_last_port", last_rsp_port, 1);

      // spurious memory response while idle
      spur_req = 1'b1;
      repeat (4) @(negedge clk_i);
      chk("spurious_err", err_o, 1);
      pq[1].push_back(mk(32'h400, 1'b0, '0));
      wait_idle("after_spurious", 200);
      chk("after_spurious_port", last_rsp_port, 1);

      // mismatched response address
      do_reset("rst1");
      corrupt_req = 1'b1;
      pq[0].push_back(mk(32'h100, 1'b0, '0));
      wait_idle("mismatch", 200);
      chk("mismatch_err", err_o, 1);
      chk("mismatch_addr", last_rsp_addr, 32'h104);
      chk("mismatch_data", last_rsp_data, a5_line);

      // reset while waiting for memory
      do_reset("rst2");
      lat = 20;
      pq[0].push_back(mk(32'h500, 1'b0, '0));
      n = 0;
      while (!m_wait && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("reached_wait_rsp", m_wait, 1);
      do_reset("rst_wait");
      lat = 10;
      pq[1].push_back(mk(32'h600, 1'b0, '0));
      wait_idle("post_reset", 200);
      chk("post_reset_port", last_rsp_port, 1);
      chk("post_reset_addr", last_rsp_addr, 32'h600);
      chk("post_reset_data", last_rsp_data, read_ref(32'h600));

      // randomized traffic
      rsp_rand = 1'b1;
      rdy_rand = 1'b1;
      lat_random = 1'b1;
      d0 = done_count;
      for (int i = 0; i < 40; i++) begin
         pp = int'($urandom_range(0, 1));
         pq[pp].push_back(mk(32'h8000 + {$urandom_range(0, 7), 4'h0}, 1'($urandom_range(0, 1)),
                             {$urandom, $urandom, $urandom, $urandom}));
      end
      wait_idle("random", 5000);
      chk("random_done", done_count - d0, 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
